// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// default memory size and a funct3 legality helper.
package load_store_unit_pkg;

  localparam int MEM_BYTES_DEFAULT = 512;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Stores only have byte/half/word; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
    if (is_write) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: extracts/extends a load lane from a memory word
// and merges store data into a word for the read-modify-write path.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and build both the load value and merged word.
  always_comb begin
    byte_sel   = word[{addr_lo, 3'b000} +: 8];
    half_sel   = word[{addr_lo[1], 4'b0000} +: 16];

    load_val = '0;
    case (funct3)
      F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_val = word;
      F3_LBU:  load_val = {24'd0, byte_sel};
      F3_LHU:  load_val = {16'd0, half_sel};
      default: load_val = '0;
    endcase

    store_word = word;
    case (funct3)
      F3_SB:   store_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_SH:   store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      F3_SW:   store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts RISC-V byte/half/word accesses into whole-word
// memory accesses, with read-modify-write for SB/SH and fault reporting.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_idx,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rdw_q, rdw_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] mem_idx_q, mem_idx_d;
  logic        mem_we_q, mem_we_d;

  logic        req_fault;
  logic [31:0] load_val;
  logic [31:0] store_word;

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .word       (rdw_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // Classify the incoming request as a fault before it is captured.
  always_comb begin
    req_fault = !f3_legal(req_write, req_funct3) ||
                ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                (req_addr >= 32'(MEM_BYTES));
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    rdw_d        = rdw_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    mem_idx_d    = '0;
    mem_we_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          write_d  = req_write;
          if (req_fault) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_write && (req_funct3 == F3_SW)) begin
            // Full-word stores need no read, go straight to the write.
            state_d   = ST_WRITE;
            mem_idx_d = {req_addr[31:2], 2'b00};
            mem_we_d  = 1'b1;
          end else begin
            state_d   = ST_READ;
            mem_idx_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      ST_READ: begin
        rdw_d = mem_read_data;
        if (write_q) begin
          state_d   = ST_WRITE;
          mem_idx_d = {addr_q[31:2], 2'b00};
          mem_we_d  = 1'b1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rdw_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      mem_idx_q    <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      rdw_q        <= rdw_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      mem_idx_q    <= mem_idx_d;
      mem_we_q     <= mem_we_d;
    end
  end

  // Handshake and write strobe are forced low while reset is asserted.
  assign req_ready        = (state_q == ST_IDLE) && rst_n;
  assign mem_write_enable = mem_we_q && rst_n;
  assign mem_idx          = mem_idx_q;
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  // Data outputs are lane decodes of registered state; zero outside their window.
  assign mem_write_data   = (state_q == ST_WRITE) ? store_word : '0;
  assign resp_rdata       = (resp_valid_q && !resp_error_q && !write_q) ? load_val : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// accesses compared against a byte-addressed reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_idx;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(512)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_idx          (mem_idx),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  // Environment memory: combinational read, written on the clock edge.
  logic [31:0] mem [0:255];
  assign mem_read_data = mem[mem_idx[9:2]];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_idx[9:2]] <= mem_write_data;
  end

  // Reference model: plain byte-addressed memory.
  logic [7:0] ref_mem [0:511];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // Architectural outcome of one access, updating the reference memory.
  task automatic ref_eval(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                          output int lat, output logic [31:0] wword);
    int size;
    bit legal;
    longint val;
    size  = 1 << f3[1:0];
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((a % size) != 0) || (a >= 512);
    rdata = '0;
    wword = '0;
    if (err) begin
      lat = 1;
    end else if (wr) begin
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      wword = ref_word(int'(a));
      lat   = (size == 4) ? 2 : 3;
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val = val | (longint'(ref_mem[int'(a) + i]) << (8*i));
      if (!f3[2] && size < 4 && val >= (longint'(1) << (8*size - 1)))
        val = val - (longint'(1) << (8*size));
      rdata = val[31:0];
      lat   = 2;
    end
  endtask

  task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
    logic        e_err;
    logic [31:0] e_rd;
    logic [31:0] e_word;
    int          e_lat;
    int          lat = 0;
    int          we_cnt = 0;
    logic [31:0] w_idx = '0;
    logic [31:0] w_data = '0;
    logic        got = 1'b0;
    logic        busy_ready = 1'b0;
    ref_eval(wr, f3, a, wd, e_err, e_rd, e_lat, e_word);
    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (req_ready) busy_ready = 1'b1;
      if (mem_write_enable) begin
        we_cnt++;
        w_idx  = mem_idx;
        w_data = mem_write_data;
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
        chk({tag, " error"}, 32'(resp_error), 32'(e_err));
        chk({tag, " rdata"}, resp_rdata, e_rd);
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " busy_ready"}, 32'(busy_ready), 32'd0);
    chk({tag, " we_pulses"}, 32'(we_cnt), (wr && !e_err) ? 32'd1 : 32'd0);
    if (wr && !e_err) begin
      chk({tag, " wr_idx"}, w_idx, {a[31:2], 2'b00});
      chk({tag, " wr_data"}, w_data, e_word);
    end
    $display("%s wr=%0d f3=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d we=%0d",
             tag, wr, f3, a, wd, resp_error, resp_rdata, lat, we_cnt);
  endtask

  initial begin
    logic [31:0] r;
    logic        we_seen;
    logic        rv_seen;
    for (int w = 0; w < 256; w++) begin
      r = $urandom;
      mem[w] = r;
      if (w < 128) for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = r[8*b +: 8];
    end
    mem[2] = 32'hDEADBEEF;
    ref_mem[8] = 8'hEF; ref_mem[9] = 8'hBE; ref_mem[10] = 8'hAD; ref_mem[11] = 8'hDE;

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready_low", 32'(req_ready), 32'd0);
    chk("rst we_low", 32'(mem_write_enable), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_error", 32'(resp_error), 32'd0);
    chk("rst mem_idx", mem_idx, 32'd0);
    chk("rst wdata", mem_write_data, 32'd0);
    chk("rst we", 32'(mem_write_enable), 32'd0);

    // Directed cases
    do_access(1'b0, 3'b000, 32'h9, 32'h0, "lb_9");
    do_access(1'b0, 3'b100, 32'h9, 32'h0, "lbu_9");
    do_access(1'b0, 3'b101, 32'hA, 32'h0, "lhu_a");
    do_access(1'b1, 3'b000, 32'hB, 32'h12, "sb_b");
    chk("sb_b mem_word", mem[2], 32'h12ADBEEF);
    do_access(1'b0, 3'b010, 32'h6, 32'h0, "lw_6");
    do_access(1'b1, 3'b001, 32'h3, 32'hABCD, "sh_3");
    do_access(1'b0, 3'b011, 32'h8, 32'h0, "ld_f3_011");
    do_access(1'b0, 3'b010, 32'h200, 32'h0, "lw_200");
    do_access(1'b1, 3'b010, 32'h4, 32'hCAFEF00D, "sw_4");
    do_access(1'b0, 3'b010, 32'h4, 32'h0, "lw_4");
    do_access(1'b1, 3'b001, 32'h12, 32'h5A5A8001, "sh_12");
    do_access(1'b0, 3'b001, 32'h12, 32'h0, "lh_12");

    // Reset asserted while an SB is in its READ cycle
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    we_seen = 1'b0;
    rv_seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (mem_write_enable) we_seen = 1'b1;
      if (resp_valid) rv_seen = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mem_write_enable) we_seen = 1'b1;
      if (resp_valid) rv_seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid we_seen", 32'(we_seen), 32'd0);
    chk("rst_mid resp_seen", 32'(rv_seen), 32'd0);
    chk("rst_mid ready", 32'(req_ready), 32'd1);
    chk("rst_mid mem_word", mem[4], ref_word(32'h10));
    $display("rst_mid SB addr=00000010 dropped we_seen=%0d resp_seen=%0d", we_seen, rv_seen);

    // Randomized accesses
    for (int n = 0; n < 150; n++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 600));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(($urandom_range(0, 1) != 0) ? 3 : 1);
      do_access(wr, f3, a, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
